// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: funct3 access codes and FSM states.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        DMEM_IDLE,
        DMEM_WAIT
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store enables/replication, load extraction
// with sign/zero extension, and misalignment/illegal-size detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_rep,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        illegal
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    assign byte_sel = load_word[{byte_off, 3'b000} +: 8];
    assign half_sel = byte_off[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        byte_en   = 4'b0000;
        store_rep = store_data;
        load_data = load_word;
        misalign  = 1'b0;
        illegal   = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << byte_off;
                store_rep = {4{store_data[7:0]}};
                load_data = (funct3 == F3_B) ? 32'(byte_sel) : {24'd0, byte_sel};
            end
            F3_H, F3_HU: begin
                misalign  = byte_off[0];
                byte_en   = byte_off[1] ? 4'b1100 : 4'b0011;
                store_rep = {2{store_data[15:0]}};
                load_data = (funct3 == F3_H) ? 32'(half_sel) : {16'd0, half_sel};
            end
            F3_W: begin
                misalign = |byte_off;
                byte_en  = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_dmem.sv
// MEM-stage data memory: byte-enabled word array with optional wait states,
// registered load return to WB and a combinational stall request.
module pipelined_dmem
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_stall,
    output logic        o_fault
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WAIT_N = 3'(WAIT_CYCLES);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [31:0]      load_word;
    logic [3:0]       byte_en;
    logic [31:0]      store_rep;
    logic [31:0]      load_data;
    logic             misalign;
    logic             illegal;
    logic             req;
    logic             fault_req;
    logic             ok_req;
    logic             complete;
    logic             unused_addr_hi;

    dmem_state_t state, state_nx;
    logic [2:0]  cnt, cnt_nx;

    // Addresses wrap modulo the array size; upper bits are deliberately ignored.
    assign idx            = i_addr[2 +: IDX_W];
    assign unused_addr_hi = ^i_addr[31:2+IDX_W];
    assign load_word      = mem[idx];

    dmem_lane_align u_align (
        .funct3     (i_funct3),
        .byte_off   (i_addr[1:0]),
        .store_data (i_wdata),
        .load_word  (load_word),
        .byte_en    (byte_en),
        .store_rep  (store_rep),
        .load_data  (load_data),
        .misalign   (misalign),
        .illegal    (illegal)
    );

    assign req       = i_mem_read | i_mem_write;
    assign fault_req = req & (misalign | illegal | (i_mem_read & i_mem_write));
    assign ok_req    = req & ~fault_req;
    assign o_stall   = ok_req & ~complete;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        complete = 1'b0;
        case (state)
            DMEM_IDLE: begin
                if (ok_req) begin
                    if (WAIT_CYCLES == 0) begin
                        complete = 1'b1;
                    end else begin
                        state_nx = DMEM_WAIT;
                        cnt_nx   = 3'd1;
                    end
                end
            end
            DMEM_WAIT: begin
                // A request vanishing mid-wait abandons the access silently.
                if (!ok_req) begin
                    state_nx = DMEM_IDLE;
                    cnt_nx   = 3'd0;
                end else if (cnt == WAIT_N) begin
                    complete = 1'b1;
                    state_nx = DMEM_IDLE;
                    cnt_nx   = 3'd0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            default: begin
                state_nx = DMEM_IDLE;
                cnt_nx   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= DMEM_IDLE;
            cnt      <= 3'd0;
            o_rvalid <= 1'b0;
            o_fault  <= 1'b0;
            o_rdata  <= 32'd0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            o_rvalid <= complete & i_mem_read;
            o_fault  <= fault_req;
            if (complete && i_mem_read) begin
                o_rdata <= load_data;
            end
        end
    end

    // Array contents survive reset; only a completing, non-reset store writes.
    always_ff @(posedge i_clk) begin
        if (!i_reset && complete && i_mem_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= store_rep[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_dmem.sv
// Bench for pipelined_dmem: zero-wait instance driven from a vector table, three-wait
// instance driven by hand-written sequences; load results checked via scoreboard queues.
module tb_pipelined_dmem;
    import dmem_pkg::*;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd0, wr0, rd3, wr3;
    logic [2:0]  f3_0, f3_3;
    logic [31:0] addr0, wdata0, addr3, wdata3;
    logic [31:0] o_rdata0, o_rdata3;
    logic        o_rvalid0, o_stall0, o_fault0;
    logic        o_rvalid3, o_stall3, o_fault3;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] q0[$];
    logic [31:0] q3[$];
    logic [31:0] last0 = 32'd0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    pipelined_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_mem_read(rd0), .i_mem_write(wr0),
        .i_funct3(f3_0), .i_addr(addr0), .i_wdata(wdata0),
        .o_rdata(o_rdata0), .o_rvalid(o_rvalid0), .o_stall(o_stall0), .o_fault(o_fault0)
    );

    pipelined_dmem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_reset(rst), .i_mem_read(rd3), .i_mem_write(wr3),
        .i_funct3(f3_3), .i_addr(addr3), .i_wdata(wdata3),
        .o_rdata(o_rdata3), .o_rvalid(o_rvalid3), .o_stall(o_stall3), .o_fault(o_fault3)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Scoreboard: every o_rvalid must match the oldest outstanding load.
    always @(negedge clk) begin
        if (o_rvalid0) begin
            if (q0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
            else check("load0", o_rdata0, q0.pop_front());
        end
        if (o_rvalid3) begin
            if (q3.size() == 0) check("rvalid3_unexpected", 32'd1, 32'd0);
            else check("load3", o_rdata3, q3.pop_front());
        end
    end

    task automatic add(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic fault, input logic [31:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.fault = fault; v.rdata = rdata;
        vecs.push_back(v);
    endtask

    task automatic apply0(input vec_t v, input int k);
        logic [31:0] hold;
        @(negedge clk);
        rd0 = v.rd; wr0 = v.wr; f3_0 = v.f3; addr0 = v.addr; wdata0 = v.wdata;
        hold = last0;
        if (v.rd && !v.fault) begin
            q0.push_back(v.rdata);
            last0 = v.rdata;
        end
        #1 check($sformatf("stall0[%0d]", k), {31'd0, o_stall0}, 32'd0);
        @(posedge clk);
        #1 check($sformatf("fault0[%0d]", k), {31'd0, o_fault0}, {31'd0, v.fault});
        if (v.fault) check($sformatf("rdata_hold0[%0d]", k), o_rdata0, hold);
    endtask

    // Holds a request on the 3-wait instance, counts stall cycles, checks data timing.
    task automatic run3(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input string tag);
        int stalls = 0;
        @(negedge clk);
        rd3 = rd; wr3 = wr; f3_3 = F3_W; addr3 = addr; wdata3 = wdata;
        if (rd) q3.push_back(exp_data);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!o_stall3) break;
            stalls++;
            @(negedge clk);
        end
        check({tag, "_stalls"}, stalls, 32'd3);
        check({tag, "_rvalid_early"}, {31'd0, o_rvalid3}, 32'd0);
        @(negedge clk);
        rd3 = 1'b0; wr3 = 1'b0;
        check({tag, "_rvalid_cycle5"}, {31'd0, o_rvalid3}, {31'd0, rd});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rd0 = 0; wr0 = 0; f3_0 = F3_W; addr0 = 0; wdata0 = 0;
        rd3 = 0; wr3 = 0; f3_3 = F3_W; addr3 = 0; wdata3 = 0;

        add(0, 1, F3_W,   32'h10,   32'hDEADBEEF, 0, 32'h0);
        add(1, 0, F3_W,   32'h10,   32'h0,        0, 32'hDEADBEEF);
        add(0, 1, F3_W,   32'h10,   32'h0,        0, 32'h0);
        add(0, 1, F3_B,   32'h13,   32'h12345680, 0, 32'h0);
        add(1, 0, F3_B,   32'h13,   32'h0,        0, 32'hFFFFFF80);
        add(1, 0, F3_BU,  32'h13,   32'h0,        0, 32'h00000080);
        add(1, 0, F3_HU,  32'h12,   32'h0,        0, 32'h00008000);
        add(1, 0, F3_H,   32'h12,   32'h0,        0, 32'hFFFF8000);
        add(1, 0, F3_W,   32'h10,   32'h0,        0, 32'h80000000);
        add(0, 1, F3_W,   32'h04,   32'h11223344, 0, 32'h0);
        add(1, 0, F3_W,   32'h02,   32'h0,        1, 32'h0);
        add(0, 1, F3_H,   32'h05,   32'h0000BEEF, 1, 32'h0);
        add(1, 0, F3_W,   32'h04,   32'h0,        0, 32'h11223344);
        add(1, 0, F3_B,   32'h05,   32'h0,        0, 32'h00000033);
        add(1, 0, F3_HU,  32'h06,   32'h0,        0, 32'h00001122);
        add(0, 1, F3_H,   32'h06,   32'h5555ABCD, 0, 32'h0);
        add(1, 0, F3_W,   32'h04,   32'h0,        0, 32'hABCD3344);
        add(1, 0, F3_H,   32'h04,   32'h0,        0, 32'h00003344);
        add(1, 0, 3'b011, 32'h04,   32'h0,        1, 32'h0);
        add(1, 1, F3_W,   32'h04,   32'hFFFFFFFF, 1, 32'h0);
        add(0, 1, 3'b110, 32'h04,   32'h0,        1, 32'h0);
        add(1, 0, F3_W,   32'h04,   32'h0,        0, 32'hABCD3344);
        add(1, 0, F3_B,   32'h07,   32'h0,        0, 32'hFFFFFFAB);
        add(0, 1, F3_W,   32'h1000, 32'h00001234, 0, 32'h0);
        add(1, 0, F3_W,   32'h0,    32'h0,        0, 32'h00001234);

        repeat (3) @(negedge clk);
        check("reset_rdata0",  o_rdata0, 32'd0);
        check("reset_rvalid0", {31'd0, o_rvalid0}, 32'd0);
        check("reset_fault0",  {31'd0, o_fault0}, 32'd0);
        check("reset_stall0",  {31'd0, o_stall0}, 32'd0);
        check("reset_rdata3",  o_rdata3, 32'd0);
        check("reset_stall3",  {31'd0, o_stall3}, 32'd0);
        rst = 1'b0;

        foreach (vecs[k]) apply0(vecs[k], k);
        @(negedge clk);
        rd0 = 0; wr0 = 0;
        repeat (2) @(negedge clk);
        check("q0_drained", q0.size(), 32'd0);

        run3(0, 1, 32'h20, 32'hCAFEF00D, 32'h0,        "sw3");
        run3(1, 0, 32'h20, 32'h0,        32'hCAFEF00D, "lw3");

        // Reset on the second WAIT cycle of a store: store discarded, no rvalid.
        @(negedge clk);
        wr3 = 1'b1; f3_3 = F3_W; addr3 = 32'h20; wdata3 = 32'h55AA55AA;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr3 = 1'b0;
        #1 check("rst_wait_stall3",  {31'd0, o_stall3}, 32'd0);
        check("rst_wait_rvalid3", {31'd0, o_rvalid3}, 32'd0);
        run3(1, 0, 32'h20, 32'h0, 32'hCAFEF00D, "lw3_after_rst");

        // Request dropped after one WAIT cycle: no access, next access fully waits.
        @(negedge clk);
        rd3 = 1'b1; f3_3 = F3_W; addr3 = 32'h20;
        @(negedge clk);
        rd3 = 1'b0;
        repeat (2) @(negedge clk);
        check("drop_rvalid3", {31'd0, o_rvalid3}, 32'd0);
        run3(1, 0, 32'h20, 32'h0, 32'hCAFEF00D, "lw3_after_drop");

        // Misaligned load on the waited instance: no stall, one-cycle fault.
        @(negedge clk);
        rd3 = 1'b1; f3_3 = F3_W; addr3 = 32'h22;
        #1 check("mis3_stall", {31'd0, o_stall3}, 32'd0);
        @(posedge clk);
        #1 check("mis3_fault", {31'd0, o_fault3}, 32'd1);
        @(negedge clk);
        rd3 = 1'b0;
        @(posedge clk);
        #1 check("mis3_fault_pulse", {31'd0, o_fault3}, 32'd0);
        check("mis3_rdata_hold", o_rdata3, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        check("q3_drained", q3.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
